regfile_bp: RTL and testbench

Parametrised integer register file for the single-cycle RISC-V datapath, successor to the fixed 32x32 two-read/one-write file. It adds write-to-read bypass, a hardware clear sequencer that zeroes the array after reset or on request, and a per-register pending scoreboard for producers whose result arrives later. It sits between decode (read addresses) and writeback (write port). Register 0 stays hardwired to zero.

---
 rtl/regfile_bp_if.sv | 30 +++
 rtl/regfile_bp.sv | 117 +++++++++++
 tb/tb_regfile_bp.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_bp_if.sv
// Register-file port bundle: clear control, write port, two read ports and
// the pending scoreboard. Decode/writeback is the master, the file is the slave.
interface regfile_bp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            clear_req;
  logic            busy;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   raddr1;
  logic [AW-1:0]   raddr2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            mark;
  logic [AW-1:0]   mark_addr;
  logic            pend1;
  logic            pend2;

  modport master (
    output clear_req, we, waddr, wdata, raddr1, raddr2, mark, mark_addr,
    input  busy, rdata1, rdata2, pend1, pend2
  );

  modport slave (
    input  clear_req, we, waddr, wdata, raddr1, raddr2, mark, mark_addr,
    output busy, rdata1, rdata2, pend1, pend2
  );
endinterface

// File: rtl/regfile_bp.sv
// Integer register file with write-to-read bypass, a clear sequencer that
// zeroes the array after reset or on request, and a per-register pending
// scoreboard. Register 0 always reads as zero and is never pending.
module regfile_bp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic         clk,
  input  logic         rst,
  regfile_bp_if.slave  bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [NREG-1:0] pend_q, pend_d;

  // The array has no reset; the clear sequencer is what zeroes it.
  logic [XLEN-1:0] regs_q [NREG];

  logic            arr_we;
  logic [AW-1:0]   arr_addr;
  logic [XLEN-1:0] arr_data;

  logic busy_int;
  assign busy_int = (state_q == CLEAR);
  assign bus.busy = busy_int;

  // Sequencer state, clear counter and pending bits (async reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state for the sequencer and the scoreboard.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          pend_d  = '0;
        end else begin
          // Clear first, then set, so a same-edge mark from a new producer wins.
          if (bus.we) pend_d[bus.waddr] = 1'b0;
          if (bus.mark && (bus.mark_addr != '0)) pend_d[bus.mark_addr] = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase
    pend_d[0] = 1'b0;
  end

  // Array write port select: the sequencer owns the port while clearing.
  always_comb begin
    arr_we   = 1'b0;
    arr_addr = bus.waddr;
    arr_data = bus.wdata;
    if (busy_int) begin
      arr_we   = 1'b1;
      arr_addr = cnt_q;
      arr_data = '0;
    end else if (bus.we && (bus.waddr != '0)) begin
      arr_we = 1'b1;
    end
  end

  // Register array storage.
  always_ff @(posedge clk) begin
    if (arr_we) regs_q[arr_addr] <= arr_data;
  end

  // Combinational read ports with bypass of the in-flight write.
  always_comb begin
    bus.rdata1 = '0;
    bus.rdata2 = '0;
    bus.pend1  = 1'b0;
    bus.pend2  = 1'b0;
    if (!busy_int) begin
      if (bus.raddr1 != '0) begin
        if (bus.we && (bus.waddr == bus.raddr1)) bus.rdata1 = bus.wdata;
        else                                     bus.rdata1 = regs_q[bus.raddr1];
      end
      if (bus.raddr2 != '0) begin
        if (bus.we && (bus.waddr == bus.raddr2)) bus.rdata2 = bus.wdata;
        else                                     bus.rdata2 = regs_q[bus.raddr2];
      end
      bus.pend1 = pend_q[bus.raddr1];
      bus.pend2 = pend_q[bus.raddr2];
    end
  end

endmodule

// File: tb/tb_regfile_bp.sv
// Scoreboarded bench for regfile_bp: a 32x32 instance and a 16x64 instance
// share one stimulus bus, selected by sel. Stimulus pushes expectations;
// the monitor pops and compares them on the falling edge.
module tb_regfile_bp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic        clear_req = 1'b0;
  logic        we = 1'b0;
  logic        mark = 1'b0;
  logic [4:0]  waddr = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [4:0]  mark_addr = '0;
  logic [63:0] wdata = '0;

  regfile_bp_if #(.XLEN(32), .AW(5)) ifa ();
  regfile_bp_if #(.XLEN(64), .AW(4)) ifb ();

  assign ifa.clear_req = clear_req & ~sel;
  assign ifa.we        = we & ~sel;
  assign ifa.mark      = mark & ~sel;
  assign ifa.waddr     = waddr;
  assign ifa.raddr1    = raddr1;
  assign ifa.raddr2    = raddr2;
  assign ifa.mark_addr = mark_addr;
  assign ifa.wdata     = wdata[31:0];

  assign ifb.clear_req = clear_req & sel;
  assign ifb.we        = we & sel;
  assign ifb.mark      = mark & sel;
  assign ifb.waddr     = waddr[3:0];
  assign ifb.raddr1    = raddr1[3:0];
  assign ifb.raddr2    = raddr2[3:0];
  assign ifb.mark_addr = mark_addr[3:0];
  assign ifb.wdata     = wdata;

  regfile_bp #(.XLEN(32), .NREG(32), .AW(5)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa.slave)
  );

  regfile_bp #(.XLEN(64), .NREG(16), .AW(4)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb.slave)
  );

  logic        mon_busy, mon_p1, mon_p2;
  logic [63:0] mon_r1, mon_r2;
  assign mon_busy = sel ? ifb.busy   : ifa.busy;
  assign mon_p1   = sel ? ifb.pend1  : ifa.pend1;
  assign mon_p2   = sel ? ifb.pend2  : ifa.pend2;
  assign mon_r1   = sel ? ifb.rdata1 : {32'b0, ifa.rdata1};
  assign mon_r2   = sel ? ifb.rdata2 : {32'b0, ifa.rdata2};

  localparam int K_BUSY = 0, K_R1 = 1, K_R2 = 2, K_P1 = 3, K_P2 = 4;

  typedef struct {
    int          kind;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push_exp(input int kind, input logic [63:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: drain every expectation queued for this cycle.
  exp_t        mon_e;
  logic [63:0] mon_act;
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      case (mon_e.kind)
        K_BUSY:  mon_act = {63'b0, mon_busy};
        K_R1:    mon_act = mon_r1;
        K_R2:    mon_act = mon_r2;
        K_P1:    mon_act = {63'b0, mon_p1};
        default: mon_act = {63'b0, mon_p2};
      endcase
      n_checks++;
      if (mon_act === mon_e.exp) begin
        n_pass++;
        $display("ok   %s = %h", mon_e.name, mon_act);
      end else begin
        $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rst(input logic s, input logic v);
    if (s) rst_b = v;
    else   rst_a = v;
  endtask

  // Called right after rst release (0 edges done): busy for exactly n edges.
  task automatic clear_window(input int n, input string tag);
    for (int k = 0; k <= n; k++) begin
      push_exp(K_BUSY, {63'b0, (k < n)}, $sformatf("%s_busy_e%0d", tag, k));
      step();
    end
  endtask

  task automatic read_all(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(n - 1 - i);
      push_exp(K_R1, 64'd0, $sformatf("%s_r1_x%0d", tag, i));
      push_exp(K_R2, 64'd0, $sformatf("%s_r2_x%0d", tag, n - 1 - i));
      push_exp(K_P1, 64'd0, $sformatf("%s_p1_x%0d", tag, i));
      push_exp(K_P2, 64'd0, $sformatf("%s_p2_x%0d", tag, n - 1 - i));
      step();
    end
  endtask

  function automatic logic [63:0] pat(input int i, input logic [63:0] m);
    return (64'h0101010101010101 * 64'(i)) & m;
  endfunction

  task automatic run(input logic s, input int n, input logic [63:0] m, input string tag);
    logic [63:0] v1, v2;
    v1 = 64'hA5A55A5A_C3C33C3C & m;
    v2 = 64'h0F0F1234_7777ABCD & m;
    sel = s;
    clear_req = 0; we = 0; mark = 0; waddr = 0; wdata = 0;
    mark_addr = 0; raddr1 = 5; raddr2 = 0;

    $display("---- %s: reset and initial clear", tag);
    set_rst(s, 1'b1);
    step();
    push_exp(K_BUSY, 64'd1, {tag, "_rst_busy"});
    push_exp(K_R1,   64'd0, {tag, "_rst_rdata1"});
    push_exp(K_P1,   64'd0, {tag, "_rst_pend1"});
    step();
    set_rst(s, 1'b0);
    clear_window(n, {tag, "_rel"});
    read_all(n, {tag, "_post_rst"});

    $display("---- %s: bypass", tag);
    we = 1; waddr = 5; wdata = 64'h0BADF00D_DEADBEEF; raddr1 = 5;
    push_exp(K_R1, 64'h0BADF00D_DEADBEEF & m, {tag, "_x5_bypass"});
    step();
    we = 0;
    push_exp(K_R1, 64'h0BADF00D_DEADBEEF & m, {tag, "_x5_array"});
    step();

    we = 1; waddr = 0; wdata = 64'h12345678; raddr1 = 0; raddr2 = 0;
    push_exp(K_R1, 64'd0, {tag, "_x0_same_r1"});
    push_exp(K_R2, 64'd0, {tag, "_x0_same_r2"});
    step();
    we = 0;
    push_exp(K_R1, 64'd0, {tag, "_x0_after"});
    step();

    $display("---- %s: scoreboard", tag);
    raddr1 = 7; raddr2 = 7; mark = 1; mark_addr = 7;
    push_exp(K_P1, 64'd0, {tag, "_mark7_nobypass"});
    step();
    mark = 0;
    push_exp(K_P1, 64'd1, {tag, "_mark7_set"});
    we = 1; waddr = 7; wdata = v1;
    push_exp(K_P1, 64'd1, {tag, "_wr7_pend_still"});
    push_exp(K_R1, v1,    {tag, "_wr7_bypass"});
    step();
    we = 0;
    push_exp(K_P1, 64'd0, {tag, "_wr7_pend_clr"});
    push_exp(K_R1, v1,    {tag, "_wr7_array"});
    step();
    mark = 1; mark_addr = 7; we = 1; waddr = 7; wdata = v2;
    push_exp(K_R1, v2, {tag, "_markwr7_bypass"});
    step();
    mark = 0; we = 0;
    push_exp(K_P1, 64'd1, {tag, "_markwr7_p1"});
    push_exp(K_P2, 64'd1, {tag, "_markwr7_p2"});
    push_exp(K_R1, v2,    {tag, "_markwr7_r1"});
    step();
    mark = 1; mark_addr = 0; raddr1 = 0;
    step();
    mark = 0;
    push_exp(K_P1, 64'd0, {tag, "_mark0_ignored"});
    step();

    $display("---- %s: fill then clear_req", tag);
    for (int i = 1; i < n; i++) begin
      we = 1; waddr = 5'(i); wdata = pat(i, m); raddr2 = 5'(i);
      push_exp(K_R2, pat(i, m), $sformatf("%s_fill_x%0d", tag, i));
      step();
    end
    we = 0;
    mark = 1; mark_addr = 9;
    step();
    mark = 0; raddr1 = 9; raddr2 = 5'(n - 1);
    push_exp(K_R1, pat(9, m),     {tag, "_fill_rb_x9"});
    push_exp(K_R2, pat(n - 1, m), {tag, "_fill_rb_last"});
    push_exp(K_P1, 64'd1,         {tag, "_fill_pend9"});
    step();

    clear_req = 1;
    push_exp(K_BUSY, 64'd0, {tag, "_creq_idle"});
    step();
    clear_req = 0;
    we = 1; waddr = 3; wdata = m; mark = 1; mark_addr = 4; raddr1 = 3; raddr2 = 4;
    for (int k = 1; k <= n; k++) begin
      push_exp(K_BUSY, 64'd1, $sformatf("%s_creq_busy_e%0d", tag, k));
      push_exp(K_R1,   64'd0, $sformatf("%s_creq_r1_e%0d", tag, k));
      push_exp(K_P2,   64'd0, $sformatf("%s_creq_p2_e%0d", tag, k));
      step();
    end
    we = 0; mark = 0;
    push_exp(K_BUSY, 64'd0, {tag, "_creq_done"});
    step();
    read_all(n, {tag, "_post_creq"});

    $display("---- %s: reset mid-clear", tag);
    set_rst(s, 1'b1);
    step();
    set_rst(s, 1'b0);
    for (int k = 0; k < 10; k++) begin
      push_exp(K_BUSY, 64'd1, $sformatf("%s_pre_e%0d", tag, k));
      step();
    end
    set_rst(s, 1'b1);
    push_exp(K_BUSY, 64'd1, {tag, "_rst_cnt10"});
    step();
    set_rst(s, 1'b0);
    clear_window(n, {tag, "_rerel"});
    raddr1 = 5; raddr2 = 7;
    push_exp(K_R1, 64'd0, {tag, "_rerel_x5"});
    push_exp(K_R2, 64'd0, {tag, "_rerel_x7"});
    step();
  endtask

  initial begin
    run(1'b0, 32, 64'h00000000_FFFFFFFF, "a32");
    run(1'b1, 16, 64'hFFFFFFFF_FFFFFFFF, "b64");
    step();
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
